// File: rtl/hiscore_ctrl.sv
// High-score save/restore controller between the HPS ioctl interface and a spare game RAM port.
// Optional HISCORE_PAUSE_EN: hold the game CPU while the shared RAM port is in use.
module hiscore_ctrl #(
  parameter int unsigned ENTRY_AW     = 4,
  parameter int unsigned DATA_AW      = 8,
  parameter int unsigned RAM_AW       = 10,
  parameter logic [7:0]  CFG_INDEX    = 8'd3,
  parameter logic [7:0]  DATA_INDEX   = 8'd4,
  parameter logic [23:0] DELAY_CYCLES = 24'h7FFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic [7:0]        ioctl_din,
  output logic [RAM_AW-1:0] ram_address,
  input  logic [7:0]        ram_din,
  output logic [7:0]        data_to_ram,
  output logic              ram_write,
  output logic              pause_cpu,
  output logic              restored,
  output logic              cfg_error
);

  localparam int unsigned NumEnt  = 2 ** ENTRY_AW;
  localparam int unsigned BufSize = 2 ** DATA_AW;
  localparam int unsigned CumW    = (ENTRY_AW + 9 > DATA_AW + 1) ? ENTRY_AW + 9 : DATA_AW + 1;

  typedef enum logic [2:0] {StIdle, StVstart, StVend, StDelay, StWrite, StDone} state_e;

  logic [RAM_AW-1:0] ent_addr_q  [NumEnt];
  logic [7:0]        ent_len_q   [NumEnt];
  logic [7:0]        ent_smark_q [NumEnt];
  logic [7:0]        ent_emark_q [NumEnt];
  logic [CumW-1:0]   cum_start_q [NumEnt];
  logic [7:0]        data_buf_q  [BufSize];
  logic [7:0]        buf_rdata_q;

  logic [ENTRY_AW:0]   num_ent_q;
  logic [ENTRY_AW-1:0] cum_idx_q;
  logic [CumW-1:0]     cum_acc_q;
  logic cfg_dl_q, data_dl_q, cfg_loaded_q, data_loaded_q, cfg_error_q, cum_busy_q;

  state_e st_q, st_d;
  logic [ENTRY_AW-1:0] ent_q, ent_d, up_ent_q, up_ent_d, ent_nxt, up_ptr, up_sel;
  logic [1:0]          cnt_q, cnt_d;
  logic [23:0]         delay_q, delay_d;
  logic [CumW-1:0]     off_q, off_d, cur_end, up_end;
  logic [RAM_AW-1:0]   ram_address_q, ram_address_d, cur_base;
  logic [7:0]          data_to_ram_q, data_to_ram_d, cur_len;
  logic                ram_write_q, ram_write_d, last_ent, upload_act;

  logic cfg_dl, data_dl, cfg_wr, data_wr, cfg_start, cfg_end, data_start, data_end;
  logic [ENTRY_AW-1:0] cfg_idx;
  logic [ENTRY_AW:0]   num_ent_cur;

  assign cfg_dl     = ioctl_download && (ioctl_index == CFG_INDEX);
  assign data_dl    = ioctl_download && (ioctl_index == DATA_INDEX);
  assign cfg_wr     = cfg_dl && ioctl_wr && (ioctl_addr[24:ENTRY_AW+3] == '0);
  assign data_wr    = data_dl && ioctl_wr && (ioctl_addr[24:DATA_AW] == '0);
  assign cfg_idx    = ioctl_addr[ENTRY_AW+2:3];
  assign cfg_start  = cfg_dl && !cfg_dl_q;
  assign cfg_end    = !cfg_dl && cfg_dl_q;
  assign data_start = data_dl && !data_dl_q;
  assign data_end   = !data_dl && data_dl_q;
  assign num_ent_cur = cfg_start ? '0 : num_ent_q;

  // Replace one big-endian address byte (lane 3 = MSB byte 0) within the RAM_AW-bit address.
  function automatic logic [RAM_AW-1:0] put_byte(input logic [RAM_AW-1:0] old,
                                                 input int lane, input logic [7:0] b);
    logic [RAM_AW-1:0] r;
    r = old;
    for (int i = 0; i < RAM_AW; i++) begin
      if (i / 8 == lane) r[i] = b[i % 8];
    end
    return r;
  endfunction

  // Table and buffer storage: no reset, contents are only trusted once the loaded flags are set.
  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      case (ioctl_addr[2:0])
        3'd0:    ent_addr_q[cfg_idx]  <= put_byte(ent_addr_q[cfg_idx], 3, ioctl_dout);
        3'd1:    ent_addr_q[cfg_idx]  <= put_byte(ent_addr_q[cfg_idx], 2, ioctl_dout);
        3'd2:    ent_addr_q[cfg_idx]  <= put_byte(ent_addr_q[cfg_idx], 1, ioctl_dout);
        3'd3:    ent_addr_q[cfg_idx]  <= put_byte(ent_addr_q[cfg_idx], 0, ioctl_dout);
        3'd4:    ent_len_q[cfg_idx]   <= ioctl_dout;
        3'd5:    ent_smark_q[cfg_idx] <= ioctl_dout;
        3'd6:    ent_emark_q[cfg_idx] <= ioctl_dout;
        default: ;
      endcase
    end
    if (cum_busy_q) cum_start_q[cum_idx_q] <= cum_acc_q;
    if (data_wr) data_buf_q[ioctl_addr[DATA_AW-1:0]] <= ioctl_dout;
    buf_rdata_q <= data_buf_q[off_d[DATA_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      num_ent_q     <= '0;
      cum_idx_q     <= '0;
      cum_acc_q     <= '0;
      cfg_dl_q      <= 1'b0;
      data_dl_q     <= 1'b0;
      cfg_loaded_q  <= 1'b0;
      data_loaded_q <= 1'b0;
      cfg_error_q   <= 1'b0;
      cum_busy_q    <= 1'b0;
      st_q          <= StIdle;
      ent_q         <= '0;
      up_ent_q      <= '0;
      cnt_q         <= '0;
      delay_q       <= '0;
      off_q         <= '0;
      ram_address_q <= '0;
      data_to_ram_q <= '0;
      ram_write_q   <= 1'b0;
    end else begin
      cfg_dl_q  <= cfg_dl;
      data_dl_q <= data_dl;
      if (cfg_start) begin
        cfg_loaded_q <= 1'b0;
        cfg_error_q  <= 1'b0;
        cum_busy_q   <= 1'b0;
        cum_acc_q    <= '0;
      end else if (cfg_end) begin
        cum_acc_q <= '0;
        cum_idx_q <= '0;
        if (num_ent_q == '0) cfg_loaded_q <= 1'b1;
        else                 cum_busy_q   <= 1'b1;
      end else if (cum_busy_q) begin
        // Serial prefix sum: one entry per cycle, total length left in cum_acc_q.
        cum_acc_q <= cum_acc_q + CumW'(ent_len_q[cum_idx_q]);
        cum_idx_q <= cum_idx_q + 1'b1;
        if ({1'b0, cum_idx_q} == num_ent_q - 1'b1) begin
          cum_busy_q   <= 1'b0;
          cfg_loaded_q <= 1'b1;
          cfg_error_q  <= (cum_acc_q + CumW'(ent_len_q[cum_idx_q])) > CumW'(BufSize);
        end
      end
      if (cfg_wr && ({1'b0, cfg_idx} >= num_ent_cur)) num_ent_q <= {1'b0, cfg_idx} + 1'b1;
      else if (cfg_start) num_ent_q <= '0;
      if (data_start)    data_loaded_q <= 1'b0;
      else if (data_end) data_loaded_q <= 1'b1;
      st_q          <= st_d;
      ent_q         <= ent_d;
      up_ent_q      <= up_ent_d;
      cnt_q         <= cnt_d;
      delay_q       <= delay_d;
      off_q         <= off_d;
      ram_address_q <= ram_address_d;
      data_to_ram_q <= data_to_ram_d;
      ram_write_q   <= ram_write_d;
    end
  end

  assign cur_base   = ent_addr_q[ent_q];
  assign cur_len    = ent_len_q[ent_q];
  assign cur_end    = cum_start_q[ent_q] + CumW'(cur_len);
  assign ent_nxt    = ent_q + 1'b1;
  assign last_ent   = ({1'b0, ent_q} == num_ent_q - 1'b1);
  assign upload_act = ioctl_upload && (st_q != StWrite);
  assign up_ptr     = (ioctl_addr == '0) ? '0 : up_ent_q;
  assign up_end     = cum_start_q[up_ptr] + CumW'(ent_len_q[up_ptr]);
  assign up_sel     = (ioctl_addr >= 25'(up_end)) ? up_ptr + 1'b1 : up_ptr;

  always_comb begin
    st_d          = st_q;
    ent_d         = ent_q;
    up_ent_d      = up_ent_q;
    cnt_d         = cnt_q;
    delay_d       = delay_q;
    off_d         = off_q;
    ram_address_d = ram_address_q;
    data_to_ram_d = data_to_ram_q;
    ram_write_d   = 1'b0;
    if (cfg_start || data_start) begin
      st_d  = StIdle;
      cnt_d = '0;
    end else if (upload_act) begin
      up_ent_d      = up_sel;
      ram_address_d = ent_addr_q[up_sel] + RAM_AW'(ioctl_addr - 25'(cum_start_q[up_sel]));
      // The address was stolen; cnt 2 reloads the validation address once upload ends.
      if (st_q == StVstart || st_q == StVend) cnt_d = 2'd2;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (cfg_loaded_q && data_loaded_q && !cfg_error_q && num_ent_q != '0) begin
            st_d          = StVstart;
            ent_d         = '0;
            cnt_d         = '0;
            ram_address_d = ent_addr_q[0];
          end
        end
        StVstart: begin
          if (cur_len == '0) begin
            if (last_ent) begin
              st_d    = StDelay;
              delay_d = DELAY_CYCLES;
            end else begin
              ent_d         = ent_nxt;
              cnt_d         = '0;
              ram_address_d = ent_addr_q[ent_nxt];
            end
          end else if (cnt_q == 2'd2) begin
            ram_address_d = cur_base;
            cnt_d         = '0;
          end else if (cnt_q == 2'd0) begin
            cnt_d = 2'd1;
          end else begin
            cnt_d = '0;
            if (ram_din == ent_smark_q[ent_q]) begin
              st_d          = StVend;
              ram_address_d = cur_base + RAM_AW'(cur_len) - 1'b1;
            end
          end
        end
        StVend: begin
          if (cnt_q == 2'd2) begin
            ram_address_d = cur_base + RAM_AW'(cur_len) - 1'b1;
            cnt_d         = '0;
          end else if (cnt_q == 2'd0) begin
            cnt_d = 2'd1;
          end else begin
            cnt_d = '0;
            if (ram_din == ent_emark_q[ent_q] && last_ent) begin
              st_d    = StDelay;
              delay_d = DELAY_CYCLES;
            end else if (ram_din == ent_emark_q[ent_q]) begin
              st_d          = StVstart;
              ent_d         = ent_nxt;
              ram_address_d = ent_addr_q[ent_nxt];
            end else begin
              st_d          = StVstart;
              ram_address_d = cur_base;
            end
          end
        end
        StDelay: begin
          if (delay_q == '0) begin
            st_d  = StWrite;
            ent_d = '0;
            off_d = '0;
          end else begin
            delay_d = delay_q - 1'b1;
          end
        end
        StWrite: begin
          if (off_q == cum_acc_q) begin
            st_d = StDone;
          end else if (off_q >= cur_end) begin
            ent_d = ent_nxt;  // zero-length entry: one bubble, buffer offset unchanged
          end else begin
            ram_write_d   = 1'b1;
            ram_address_d = cur_base + RAM_AW'(off_q - cum_start_q[ent_q]);
            data_to_ram_d = buf_rdata_q;
            off_d         = off_q + 1'b1;
            if (off_q + 1'b1 == cur_end) ent_d = ent_nxt;
          end
        end
        StDone: ;
        default: st_d = StIdle;
      endcase
    end
  end

`ifdef HISCORE_PAUSE_EN
  logic pause_q;
  always_ff @(posedge clk) begin
    if (!reset_n) pause_q <= 1'b0;
    else pause_q <= (st_q == StVstart) || (st_q == StVend) || (st_q == StWrite) || ioctl_upload;
  end
  assign pause_cpu = pause_q;
`else
  assign pause_cpu = 1'b0;
`endif

  assign ram_address = ram_address_q;
  assign data_to_ram = data_to_ram_q;
  assign ram_write   = ram_write_q;
  assign restored    = (st_q == StDone);
  assign cfg_error   = cfg_error_q;
  assign ioctl_din   = cfg_error_q ? 8'hFF : ram_din;

endmodule

// File: doc/hiscore_ctrl.md
# hiscore_ctrl

Parametrised high-score save/restore controller for arcade cores. It sits between the HPS ioctl download/upload interface and a spare port of the game's work RAM. It receives a table of RAM regions (config, `ioctl_index`=CFG_INDEX) and saved score bytes (data, `ioctl_index`=DATA_INDEX). Once the game has initialised each region, matched by start and end marker bytes, it writes the saved bytes into game RAM. On upload it streams the same regions back to the HPS.

## Interface
Parameters:
- `ENTRY_AW`, 4: log2 of the maximum number of region entries (16).
- `DATA_AW`, 8: log2 of the save-buffer size in bytes (256).
- `RAM_AW`, 10: game RAM address width.
- `CFG_INDEX`, 3: ioctl index carrying the region table.
- `DATA_INDEX`, 4: ioctl index carrying the saved data.
- `DELAY_CYCLES`, 24'h7FFFF: settle delay between successful validation and the first write.

Ports:
- `clk`, in, 1: sole clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `ioctl_download`, in, 1: HPS download active.
- `ioctl_upload`, in, 1: HPS upload active.
- `ioctl_wr`, in, 1: download byte strobe.
- `ioctl_addr`, in, 25: byte offset within the transfer.
- `ioctl_dout`, in, 8: download byte.
- `ioctl_index`, in, 8: transfer type.
- `ioctl_din`, out, 8: upload byte, equal to `ram_din`.
- `ram_address`, out, RAM_AW: game RAM address.
- `ram_din`, in, 8: game RAM read data, 1-cycle latency.
- `data_to_ram`, out, 8: write data.
- `ram_write`, out, 1: write strobe.
- `pause_cpu`, out, 1: CPU hold request.
- `restored`, out, 1: restore completed.
- `cfg_error`, out, 1: region table inconsistent.

## Operation
- Config entry format: 8 bytes. Bytes 0–3 are the big-endian address; the low RAM_AW bits are used. Byte 4 is length, 5 is start marker, 6 is end marker, 7 is pad. The entry index is `ioctl_addr[ENTRY_AW+2:3]`.
- Entries whose index is ≥ 2^ENTRY_AW are dropped.
- Entry count = (highest entry index written) + 1.
- After the config download ends, a serial pass of `num_entries` cycles builds a per-entry cumulative offset table.
- An entry with length 0 is skipped in every pass.
- `cfg_error` is set if the total length exceeds 2^DATA_AW. It blocks restore and upload; upload then returns 8'hFF.
- Data bytes are stored at `ioctl_addr[DATA_AW-1:0]`. Bytes at offsets ≥ 2^DATA_AW are dropped.
- FSM states: IDLE, VSTART, VEND, DELAY, WRITE, DONE.
- IDLE → VSTART when both config and data have been loaded and `cfg_error`=0.
- VSTART: drive the entry base address, wait 2 cycles, then compare `ram_din` with the start marker.
  - Match → VEND.
  - Mismatch → repeat for the same entry.
- VEND: same procedure at base+len−1, compared with the end marker.
  - Match and last entry → DELAY.
  - Match and not last entry → VSTART of the next entry.
  - Mismatch → VSTART of the same entry.
- DELAY: count DELAY_CYCLES down to 0, then → WRITE.
- WRITE: one byte per cycle with `ram_write`=1.
  - Address = entry base + (offset − cumulative entry start).
  - Entries are walked in order; the buffer offset is contiguous.
- WRITE → DONE after the last byte. DONE asserts `restored`=1.
- A new config or data download in any state returns the FSM to IDLE and clears `restored`.
- Upload (`ioctl_upload`=1, not in WRITE): the block maps `ioctl_addr` to a RAM address through the cumulative table.
  - The entry pointer resets when `ioctl_addr`=0.
  - The pointer advances when the offset reaches the current entry's cumulative end.
  - `ioctl_addr` must increment monotonically.
- Upload has priority over validation; the FSM holds its state while an upload is active.

## Timing
- Reset values:
  - `ram_write`=0, `pause_cpu`=0, `restored`=0, `cfg_error`=0, `ram_address`=0, `data_to_ram`=0.
  - FSM=IDLE; entry count and loaded flags are cleared.
- Reset mid-WRITE: `ram_write` drops on the cycle after reset is sampled low. No further writes occur.
- Upload: `ram_address` is registered 1 cycle after an `ioctl_addr` change, so `ioctl_din` is valid 2 cycles after.
- WRITE pipeline: `data_to_ram` and `ram_address` are aligned with `ram_write` in the same cycle. Buffer read latency is 1 cycle and is hidden by a 1-cycle prefetch on WRITE entry.
- Validation compare occurs exactly 2 cycles after the address is driven.
- Restore latency on a matching RAM: 4 cycles per entry for validation, plus DELAY_CYCLES + 1, plus total bytes.

## Configuration
- `HISCORE_PAUSE_EN` defined: `pause_cpu`=1 throughout VSTART, VEND, WRITE, and during active upload. It deasserts 1 cycle after leaving those states.
- `HISCORE_PAUSE_EN` undefined: `pause_cpu` is tied 0. The RAM port must be dedicated dual-port.

## Test plan
- Restore: 2 entries {0x00B, len 15, start 0x10, end 0x01} and {0x023, len 15, start 0x04, end 0x12}; 30 data bytes; RAM holds the markers → exactly 30 writes at 0x00B–0x019 and 0x023–0x031 with the buffer bytes, then `restored`=1.
- Start marker absent until cycle 1000, then written → no `ram_write` before the match; restore completes afterwards.
- Entry total 300 bytes with DATA_AW=8 → `cfg_error`=1, no writes.
- `reset_n` pulsed low during the 5th WRITE byte → `ram_write`=0 the next cycle; state IDLE; `restored`=0.
- Upload of 30 bytes after restore → `ioctl_din` sequence equals the RAM contents of both regions in order.
- Macro off → `pause_cpu`=0 for the whole restore; macro on → `pause_cpu`=1 during validation and write.
